// File: rtl/hpdcache_cmo_arbiter.sv
// Round-robin arbiter sharing the HPDcache CMO request port between NREQ requesters.
// Serialises CMOs; whole-cache ops hold the ack until the dcache reports drained.
module hpdcache_cmo_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned TID_W  = 6,
    parameter int unsigned SID_W  = 3,
    parameter int unsigned OP_W   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*OP_W-1:0]   req_op_i,
    input  logic [NREQ*TID_W-1:0]  req_tid_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [TID_W-1:0]       ack_tid_o,
    input  logic [SID_W-1:0]       dcache_sid_i,
    output logic                   dcache_req_valid_o,
    input  logic                   dcache_req_ready_i,
    output logic [ADDR_W-1:0]      dcache_req_addr_o,
    output logic [OP_W-1:0]        dcache_req_op_o,
    output logic [TID_W-1:0]       dcache_req_tid_o,
    output logic [SID_W-1:0]       dcache_req_sid_o,
    input  logic                   dcache_busy_i
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ACK} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [ADDR_W-1:0] addr_q;
    logic [OP_W-1:0]   op_q;
    logic [TID_W-1:0]  tid_q;
    logic [TID_W-1:0]  ack_tid_q;

    logic              arb_found;
    logic [PW-1:0]     arb_idx;
    logic              load;
    logic [ADDR_W-1:0] sel_addr;
    logic [OP_W-1:0]   sel_op;
    logic [TID_W-1:0]  sel_tid;

    // First valid requester at or above rr_q, wrapping modulo NREQ
    always_comb begin
        int unsigned idx;
        logic [PW-1:0] idx_p;
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = 0;
        idx_p     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_p = PW'(idx);
            if (!arb_found && req_valid_i[idx_p]) begin
                arb_found = 1'b1;
                arb_idx   = idx_p;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_op   = '0;
        sel_tid  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (PW'(i) == arb_idx) begin
                sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_op   = req_op_i[i*OP_W +: OP_W];
                sel_tid  = req_tid_i[i*TID_W +: TID_W];
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        rr_d               = rr_q;
        win_d              = win_q;
        load               = 1'b0;
        req_ready_o        = '0;
        ack_o              = '0;
        ack_tid_o          = ack_tid_q;
        dcache_req_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    req_ready_o = ONE << arb_idx;
                    load        = 1'b1;
                    win_d       = arb_idx;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                dcache_req_valid_o = 1'b1;
                if (dcache_req_ready_i) begin
                    state_d = op_q[OP_W-1] ? DRAIN : ACK;
                end
            end
            DRAIN: begin
                if (!dcache_busy_i) state_d = ACK;
            end
            ACK: begin
                ack_o     = ONE << win_q;
                ack_tid_o = tid_q;
                rr_d      = (win_q == PW'(NREQ-1)) ? '0 : win_q + PW'(1);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            win_q     <= '0;
            addr_q    <= '0;
            op_q      <= '0;
            tid_q     <= '0;
            ack_tid_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            if (load) begin
                addr_q <= sel_addr;
                op_q   <= sel_op;
                tid_q  <= sel_tid;
            end
            if (state_q == ACK) ack_tid_q <= tid_q;
        end
    end

    assign dcache_req_addr_o = addr_q;
    assign dcache_req_op_o   = op_q;
    assign dcache_req_tid_o  = tid_q;
    assign dcache_req_sid_o  = dcache_sid_i;

endmodule

// File: tb/tb_hpdcache_cmo_arbiter.sv
// Directed bench for hpdcache_cmo_arbiter: NREQ=2 instance for the main
// scenarios and an NREQ=3 instance for round-robin wrap-around.
module tb_hpdcache_cmo_arbiter;

    logic          clk;
    logic          rst_n;
    logic          dready;
    logic          busy;
    logic [2:0]    sid;

    logic [1:0]    r_valid;
    logic [1:0]    r_ready;
    logic [127:0]  r_addr;
    logic [5:0]    r_op;
    logic [11:0]   r_tid;
    logic [1:0]    ack;
    logic [5:0]    ack_tid;
    logic          dvalid;
    logic [63:0]   daddr;
    logic [2:0]    dop;
    logic [5:0]    dtid;
    logic [2:0]    dsid;

    logic [2:0]    r3_valid;
    logic [2:0]    r3_ready;
    logic [191:0]  r3_addr;
    logic [8:0]    r3_op;
    logic [17:0]   r3_tid;
    logic [2:0]    ack3;
    logic [5:0]    ack3_tid;
    logic          dvalid3;
    logic [63:0]   daddr3;
    logic [2:0]    dop3;
    logic [5:0]    dtid3;
    logic [2:0]    dsid3;

    int checks;
    int errors;

    hpdcache_cmo_arbiter #(.NREQ(2)) u_dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_valid_i        (r_valid),
        .req_ready_o        (r_ready),
        .req_addr_i         (r_addr),
        .req_op_i           (r_op),
        .req_tid_i          (r_tid),
        .ack_o              (ack),
        .ack_tid_o          (ack_tid),
        .dcache_sid_i       (sid),
        .dcache_req_valid_o (dvalid),
        .dcache_req_ready_i (dready),
        .dcache_req_addr_o  (daddr),
        .dcache_req_op_o    (dop),
        .dcache_req_tid_o   (dtid),
        .dcache_req_sid_o   (dsid),
        .dcache_busy_i      (busy)
    );

    hpdcache_cmo_arbiter #(.NREQ(3)) u_dut3 (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_valid_i        (r3_valid),
        .req_ready_o        (r3_ready),
        .req_addr_i         (r3_addr),
        .req_op_i           (r3_op),
        .req_tid_i          (r3_tid),
        .ack_o              (ack3),
        .ack_tid_o          (ack3_tid),
        .dcache_sid_i       (sid),
        .dcache_req_valid_o (dvalid3),
        .dcache_req_ready_i (dready),
        .dcache_req_addr_o  (daddr3),
        .dcache_req_op_o    (dop3),
        .dcache_req_tid_o   (dtid3),
        .dcache_req_sid_o   (dsid3),
        .dcache_busy_i      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a,
                           input logic [2:0] op, input logic [5:0] tid);
        r_addr[i*64 +: 64] = a;
        r_op[i*3 +: 3]     = op;
        r_tid[i*6 +: 6]    = tid;
    endtask

    task automatic test_reset();
        sid   = 3'd5;
        rst_n = 1'b0;
        #1;
        checks++;
        if (r_ready !== 2'b00 || ack !== 2'b00 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b ack=%b dvalid=%b want 0",
                     r_ready, ack, dvalid);
        end
        checks++;
        if (daddr !== 64'd0 || dop !== 3'd0 || dtid !== 6'd0 ||
            ack_tid !== 6'd0) begin
            errors++;
            $display("FAIL reset_regs: addr=%h op=%h tid=%h atid=%h want 0",
                     daddr, dop, dtid, ack_tid);
        end
        checks++;
        if (dsid !== 3'd5) begin
            errors++;
            $display("FAIL sid_copy: got %h want 5", dsid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        dready = 1'b1;
        set_req(0, 64'h8000_0040, 3'd2, 6'd5);
        r_valid = 2'b01;
        #1;
        checks++;
        if (r_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: got %b want 01", r_ready);
        end
        tick();
        r_valid = 2'b00;
        checks++;
        if (dvalid !== 1'b1 || daddr !== 64'h8000_0040 || dop !== 3'd2 ||
            dtid !== 6'd5) begin
            errors++;
            $display("FAIL single_issue: v=%b a=%h op=%h tid=%h want 1 80000040 2 5",
                     dvalid, daddr, dop, dtid);
        end
        tick();
        checks++;
        if (ack !== 2'b01 || ack_tid !== 6'd5 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack=%b tid=%h v=%b want 01 5 0",
                     ack, ack_tid, dvalid);
        end
        tick();
        checks++;
        if (ack !== 2'b00 || ack_tid !== 6'd5 || r_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: ack=%b tid=%h ready=%b want 00 5 00",
                     ack, ack_tid, r_ready);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        logic [5:0] et;
        do_reset();
        dready = 1'b1;
        set_req(0, 64'h1000, 3'd1, 6'd1);
        set_req(1, 64'h2000, 3'd1, 6'd2);
        r_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
            et  = (k % 2 == 1) ? 6'd2 : 6'd1;
            checks++;
            if (r_ready !== exp) begin
                errors++;
                $display("FAIL fair_grant%0d: got %b want %b", k, r_ready, exp);
            end
            tick();
            checks++;
            if (dvalid !== 1'b1 || dtid !== et) begin
                errors++;
                $display("FAIL fair_issue%0d: v=%b tid=%h want 1 %h",
                         k, dvalid, dtid, et);
            end
            tick();
            checks++;
            if (ack !== exp || ack_tid !== et) begin
                errors++;
                $display("FAIL fair_ack%0d: ack=%b tid=%h want %b %h",
                         k, ack, ack_tid, exp, et);
            end
            tick();
        end
        r_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        do_reset();
        dready = 1'b0;
        set_req(0, 64'hDEAD_BEEF_0000_0080, 3'd1, 6'd7);
        r_valid = 2'b01;
        #1;
        checks++;
        if (r_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_grant: got %b want 01", r_ready);
        end
        tick();
        r_valid = 2'b00;
        set_req(0, 64'h0, 3'd0, 6'd0);
        for (int i = 0; i < 5; i++) begin
            dready = (i == 4);
            #1;
            checks++;
            if (dvalid !== 1'b1 || daddr !== 64'hDEAD_BEEF_0000_0080 ||
                dop !== 3'd1 || dtid !== 6'd7 || ack !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%b a=%h op=%h tid=%h ack=%b",
                         i, dvalid, daddr, dop, dtid, ack);
            end
            tick();
        end
        checks++;
        if (ack !== 2'b01 || ack_tid !== 6'd7) begin
            errors++;
            $display("FAIL bp_ack: ack=%b tid=%h want 01 7", ack, ack_tid);
        end
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        dready = 1'b1;
        busy   = 1'b1;
        set_req(1, 64'h0, 3'd6, 6'd3);
        r_valid = 2'b10;
        #1;
        checks++;
        if (r_ready !== 2'b10) begin
            errors++;
            $display("FAIL drain_grant: got %b want 10", r_ready);
        end
        tick();
        r_valid = 2'b00;
        checks++;
        if (dvalid !== 1'b1 || dop !== 3'd6) begin
            errors++;
            $display("FAIL drain_issue: v=%b op=%h want 1 6", dvalid, dop);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            busy = (i < 5);
            #1;
            checks++;
            if (ack !== 2'b00 || dvalid !== 1'b0) begin
                errors++;
                $display("FAIL drain_wait%0d: ack=%b v=%b want 00 0",
                         i, ack, dvalid);
            end
            tick();
        end
        checks++;
        if (ack !== 2'b10 || ack_tid !== 6'd3) begin
            errors++;
            $display("FAIL drain_ack: ack=%b tid=%h want 10 3", ack, ack_tid);
        end
        tick();
        set_req(1, 64'h0, 3'd6, 6'd4);
        r_valid = 2'b10;
        #1;
        tick();
        r_valid = 2'b00;
        tick();
        checks++;
        if (ack !== 2'b00) begin
            errors++;
            $display("FAIL drain_min: ack=%b want 00", ack);
        end
        tick();
        checks++;
        if (ack !== 2'b10 || ack_tid !== 6'd4) begin
            errors++;
            $display("FAIL drain_fast_ack: ack=%b tid=%h want 10 4",
                     ack, ack_tid);
        end
        tick();
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        dready = 1'b1;
        busy   = 1'b1;
        set_req(0, 64'h4000, 3'd6, 6'd9);
        r_valid = 2'b01;
        #1;
        tick();
        r_valid = 2'b00;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (r_ready !== 2'b00 || ack !== 2'b00 || dvalid !== 1'b0 ||
            daddr !== 64'd0 || dop !== 3'd0 || dtid !== 6'd0 ||
            ack_tid !== 6'd0) begin
            errors++;
            $display("FAIL rst_drain: rdy=%b ack=%b v=%b a=%h op=%h tid=%h at=%h",
                     r_ready, ack, dvalid, daddr, dop, dtid, ack_tid);
        end
        tick();
        checks++;
        if (ack !== 2'b00) begin
            errors++;
            $display("FAIL rst_noack: ack=%b want 00", ack);
        end
        rst_n = 1'b1;
        busy  = 1'b0;
        set_req(0, 64'h5000, 3'd1, 6'd10);
        set_req(1, 64'h6000, 3'd1, 6'd11);
        r_valid = 2'b11;
        #1;
        checks++;
        if (r_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_rearb: got %b want 01", r_ready);
        end
        tick();
        r_valid = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        dready = 1'b1;
        busy   = 1'b0;
        r3_tid[2*6 +: 6] = 6'd9;
        r3_op[2*3 +: 3]  = 3'd1;
        r3_valid = 3'b100;
        #1;
        checks++;
        if (r3_ready !== 3'b100) begin
            errors++;
            $display("FAIL wrap_grant2: got %b want 100", r3_ready);
        end
        tick();
        r3_valid = 3'b000;
        checks++;
        if (dvalid3 !== 1'b1 || dtid3 !== 6'd9) begin
            errors++;
            $display("FAIL wrap_issue2: v=%b tid=%h want 1 9", dvalid3, dtid3);
        end
        tick();
        checks++;
        if (ack3 !== 3'b100 || ack3_tid !== 6'd9) begin
            errors++;
            $display("FAIL wrap_ack2: ack=%b tid=%h want 100 9", ack3, ack3_tid);
        end
        tick();
        r3_tid[0 +: 6] = 6'd12;
        r3_op[0 +: 3]  = 3'd1;
        r3_tid[6 +: 6] = 6'd13;
        r3_op[3 +: 3]  = 3'd1;
        r3_valid = 3'b011;
        #1;
        checks++;
        if (r3_ready !== 3'b001) begin
            errors++;
            $display("FAIL wrap_grant0: got %b want 001", r3_ready);
        end
        tick();
        r3_valid = 3'b000;
        tick();
        checks++;
        if (ack3 !== 3'b001 || ack3_tid !== 6'd12) begin
            errors++;
            $display("FAIL wrap_ack0: ack=%b tid=%h want 001 c", ack3, ack3_tid);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        dready   = 1'b0;
        busy     = 1'b0;
        sid      = 3'd0;
        r_valid  = '0;
        r_addr   = '0;
        r_op     = '0;
        r_tid    = '0;
        r3_valid = '0;
        r3_addr  = '0;
        r3_op    = '0;
        r3_tid   = '0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_drain();
        test_reset_in_drain();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
